// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer (IDLE/FETCH/EXEC/HALTED); irq path under PC_SEQ_IRQ_EN
module pc_sequencer #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] IRQ_VEC   = 8'hF0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             fetch_ack,
    input  logic             done,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             irq,
    output logic [WIDTH-1:0] pc,
    output logic             fetch_req,
    output logic             busy,
    output logic             halted,
    output logic             irq_ack,
    output logic [WIDTH-1:0] epc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] pc_next, epc_next, pc_inc;
    logic             halt_pending, halt_pending_next;
    logic             irq_taken, irq_ack_next;

    assign pc_inc = pc + 1'b1;

`ifdef PC_SEQ_IRQ_EN
    assign irq_taken = irq;
`else
    logic unused_irq;
    assign unused_irq = irq;
    assign irq_taken  = 1'b0;
`endif

    always_comb begin
        state_next        = state;
        pc_next           = pc;
        epc_next          = epc;
        halt_pending_next = halt_pending;
        irq_ack_next      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !halt) state_next = FETCH;
            end
            FETCH: begin
                if (halt) halt_pending_next = 1'b1;
                if (fetch_ack) state_next = EXEC;
            end
            EXEC: begin
                if (halt) halt_pending_next = 1'b1;
                if (done) begin
                    // irq beats jump beats sequential increment
                    if (irq_taken) begin
                        pc_next      = IRQ_VEC;
                        epc_next     = pc_inc;
                        irq_ack_next = 1'b1;
                    end else if (jump) begin
                        pc_next = jump_addr;
                    end else begin
                        pc_next = pc_inc;
                    end
                    if (halt || halt_pending) begin
                        state_next        = HALTED;
                        halt_pending_next = 1'b0;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            HALTED: begin
                if (start && !halt) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= RESET_VEC;
            epc          <= '0;
            halt_pending <= 1'b0;
            irq_ack      <= 1'b0;
            fetch_req    <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            epc          <= epc_next;
            halt_pending <= halt_pending_next;
            irq_ack      <= irq_ack_next;
            fetch_req    <= (state_next == FETCH);
        end
    end

    assign busy   = (state == FETCH) || (state == EXEC);
    assign halted = (state == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer; expectations follow PC_SEQ_IRQ_EN
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, halt, fetch_ack, done, jump, irq;
    logic [7:0] jump_addr;
    logic [7:0] pc, epc;
    logic       fetch_req, busy, halted, irq_ack;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_pc, exp_epc;
    logic       exp_ack;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .halt      (halt),
        .fetch_ack (fetch_ack),
        .done      (done),
        .jump      (jump),
        .jump_addr (jump_addr),
        .irq       (irq),
        .pc        (pc),
        .fetch_req (fetch_req),
        .busy      (busy),
        .halted    (halted),
        .irq_ack   (irq_ack),
        .epc       (epc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // one EXEC completion from FETCH: ack, then done with the given jump
    task automatic run_instr(input logic j, input logic [7:0] addr);
        fetch_ack = 1'b1; step(); fetch_ack = 1'b0;
        done = 1'b1; jump = j; jump_addr = addr; step();
        done = 1'b0; jump = 1'b0; jump_addr = 8'h00;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; halt = 1'b0; fetch_ack = 1'b0;
        done = 1'b0; jump = 1'b0; jump_addr = 8'h00; irq = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_pc", pc, 8'h00);
        check("rst_fetch_req", fetch_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_irq_ack", irq_ack, 1'b0);
        check("rst_epc", epc, 8'h00);

        // start, ack after two FETCH cycles, done -> pc 1, back in FETCH
        start = 1'b1; step(); start = 1'b0;
        check("start_fetch_req", fetch_req, 1'b1);
        check("start_busy", busy, 1'b1);
        step();
        check("fetch_hold_req", fetch_req, 1'b1);
        fetch_ack = 1'b1; step(); fetch_ack = 1'b0;
        check("exec_fetch_req", fetch_req, 1'b0);
        check("exec_busy", busy, 1'b1);
        check("exec_pc", pc, 8'h00);
        step();
        check("exec_wait_pc", pc, 8'h00);
        done = 1'b1; step(); done = 1'b0;
        check("inc_pc", pc, 8'h01);
        check("refetch_req", fetch_req, 1'b1);

        // wrap from FF to 00
        run_instr(1'b1, 8'hFF);
        check("jump_ff", pc, 8'hFF);
        run_instr(1'b0, 8'h00);
        check("wrap_pc", pc, 8'h00);

        // irq vs jump priority at pc=12
        run_instr(1'b1, 8'h12);
        check("jump_12", pc, 8'h12);
        fetch_ack = 1'b1; step(); fetch_ack = 1'b0;
        done = 1'b1; jump = 1'b1; jump_addr = 8'h40; irq = 1'b1; step();
        done = 1'b0; jump = 1'b0; jump_addr = 8'h00; irq = 1'b0;
`ifdef PC_SEQ_IRQ_EN
        exp_pc = 8'hF0; exp_epc = 8'h13; exp_ack = 1'b1;
`else
        exp_pc = 8'h40; exp_epc = 8'h00; exp_ack = 1'b0;
`endif
        check("irq_pc", pc, exp_pc);
        check("irq_epc", epc, exp_epc);
        check("irq_ack_pulse", irq_ack, exp_ack);
        step();
        check("irq_ack_clear", irq_ack, 1'b0);
        check("epc_held", epc, exp_epc);

        // halt pulse in FETCH, completion, then HALTED and restart at same pc
        halt = 1'b1; step(); halt = 1'b0;
        check("halt_fetch_busy", busy, 1'b1);
        check("halt_fetch_halted", halted, 1'b0);
        run_instr(1'b0, 8'h00);
        exp_pc = exp_pc + 8'h01;
        check("halt_pc", pc, exp_pc);
        check("halt_halted", halted, 1'b1);
        check("halt_busy", busy, 1'b0);
        check("halt_fetch_req", fetch_req, 1'b0);
        done = 1'b1; fetch_ack = 1'b1; step(); done = 1'b0; fetch_ack = 1'b0;
        check("halted_hold_pc", pc, exp_pc);
        check("halted_ignore", halted, 1'b1);
        start = 1'b1; step(); start = 1'b0;
        check("restart_req", fetch_req, 1'b1);
        check("restart_halted", halted, 1'b0);
        check("restart_pc", pc, exp_pc);

        // reset mid-EXEC at pc=33
        run_instr(1'b1, 8'h33);
        check("jump_33", pc, 8'h33);
        fetch_ack = 1'b1; step(); fetch_ack = 1'b0;
        check("exec33_busy", busy, 1'b1);
        reset = 1'b1; done = 1'b1; step(); reset = 1'b0;
        check("midexec_rst_pc", pc, 8'h00);
        check("midexec_rst_req", fetch_req, 1'b0);
        check("midexec_rst_busy", busy, 1'b0);
        step(); done = 1'b0;
        check("late_done_pc", pc, 8'h00);
        check("late_done_busy", busy, 1'b0);
        fetch_ack = 1'b1; step(); fetch_ack = 1'b0;
        check("idle_ack_ignored", busy, 1'b0);

        // start with halt in IDLE stays IDLE
        start = 1'b1; halt = 1'b1; step(); start = 1'b0; halt = 1'b0;
        check("idle_starthalt_req", fetch_req, 1'b0);
        check("idle_starthalt_busy", busy, 1'b0);

        // reset beats start
        reset = 1'b1; start = 1'b1; step(); reset = 1'b0; start = 1'b0;
        check("rst_prio_busy", busy, 1'b0);

        // irq taken with halt on the same done edge
        start = 1'b1; step(); start = 1'b0;
        fetch_ack = 1'b1; step(); fetch_ack = 1'b0;
        done = 1'b1; halt = 1'b1; irq = 1'b1; step();
        done = 1'b0; halt = 1'b0; irq = 1'b0;
`ifdef PC_SEQ_IRQ_EN
        exp_pc = 8'hF0; exp_epc = 8'h01; exp_ack = 1'b1;
`else
        exp_pc = 8'h01; exp_epc = 8'h00; exp_ack = 1'b0;
`endif
        check("irqhalt_halted", halted, 1'b1);
        check("irqhalt_pc", pc, exp_pc);
        check("irqhalt_epc", epc, exp_epc);
        check("irqhalt_ack", irq_ack, exp_ack);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: program-counter width.
REQ-002 SHALL have parameter RESET_VEC, default 0: pc value after reset.
REQ-003 SHALL have parameter IRQ_VEC, default 8'hF0: interrupt target address.
REQ-004 SHALL have port clk  input  1: single clock, rising edge; all logic synchronous to it.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port start  input  1: leave IDLE or HALTED and begin fetching.
REQ-007 SHALL have port halt  input  1: request stop after the current instruction.
REQ-008 SHALL have port fetch_ack  input  1: memory has accepted the fetch at pc.
REQ-009 SHALL have port done  input  1: current instruction has finished executing.
REQ-010 SHALL have port jump  input  1: redirect pc to jump_addr on done.
REQ-011 SHALL have port jump_addr  input  WIDTH: jump target.
REQ-012 SHALL have port irq  input  1: interrupt request, level-sensitive.
REQ-013 SHALL have port pc  output  WIDTH: current program counter, registered.
REQ-014 SHALL have port fetch_req  output  1: fetch request at pc, registered.
REQ-015 SHALL have port busy  output  1: high in FETCH or EXEC.
REQ-016 SHALL have port halted  output  1: high in HALTED.
REQ-017 SHALL have port irq_ack  output  1: one-cycle pulse when an irq is taken.
REQ-018 SHALL have port epc  output  WIDTH: return address saved on irq.

Function
REQ-019 SHALL implement four states: IDLE, FETCH, EXEC, HALTED.
REQ-020 SHALL behave as follows in IDLE: start=1 and halt=0 -> FETCH next cycle; start=1 and halt=1 -> remain in IDLE.
REQ-021 SHALL behave as follows in FETCH: fetch_req=1 every cycle; fetch_ack=1 -> EXEC next cycle, with fetch_req low from that cycle.
REQ-022 SHALL behave as follows in EXEC: remain until done=1, then update pc per REQ-023 in the same edge.
REQ-023 SHALL select the next pc on done with priority irq > jump > increment; irq -> pc<=IRQ_VEC, epc<=pc+1; jump -> pc<=jump_addr; otherwise pc<=pc+1.
REQ-024 SHALL use modulo-2^WIDTH arithmetic for pc+1, so all-ones wraps to 0, for both pc and epc.
REQ-025 SHALL latch halt=1 seen in FETCH or EXEC as halt_pending; on done go to HALTED if halt or halt_pending is set, else to FETCH; halt_pending clears on entering HALTED.
REQ-026 SHALL behave as follows in HALTED: pc held; start=1 and halt=0 -> FETCH with pc unchanged.
REQ-027 SHALL ignore fetch_ack outside FETCH and done outside EXEC.
REQ-028 SHALL assert irq_ack for exactly the cycle after the done edge that took the irq.
REQ-029 SHALL take the irq on the same done even when halt is also pending, then enter HALTED with pc=IRQ_VEC.

Reset
REQ-030 SHALL, on reset=1 at a clk edge, force IDLE, pc=RESET_VEC, epc=0, and fetch_req, busy, halted, irq_ack and halt_pending all 0, from any state including mid-FETCH or mid-EXEC.
REQ-031 SHALL give reset priority over all other inputs in the same cycle.

Configuration
REQ-032 SHALL use macro PC_SEQ_IRQ_EN; when defined, the irq behaviour of REQ-023, REQ-028 and REQ-029 is present.
REQ-033 SHALL, when PC_SEQ_IRQ_EN is undefined, ignore irq, hold irq_ack and epc at 0, and keep all ports present.

Verification
REQ-034 SHALL cover: reset, start pulse, fetch_ack after 2 cycles, done -> fetch_req high 1 cycle after start, pc goes 0 -> 1, state returns to FETCH.
REQ-035 SHALL cover: pc=8'hFF, done with no jump -> pc=8'h00.
REQ-036 SHALL cover: done with jump=1, jump_addr=8'h40, irq=1 (PC_SEQ_IRQ_EN defined), pc=8'h12 -> pc=8'hF0, epc=8'h13, irq_ack one-cycle pulse; without the macro -> pc=8'h40, irq_ack=0.
REQ-037 SHALL cover: halt pulsed 1 cycle during FETCH, then fetch_ack, then done -> pc increments, halted=1, busy=0; then start -> FETCH at the same pc.
REQ-038 SHALL cover: reset asserted mid-EXEC at pc=8'h33 -> next cycle IDLE, pc=8'h00, fetch_req=0, and a later done is ignored.
REQ-039 SHALL cover: start=1 and halt=1 together in IDLE -> remain in IDLE with fetch_req=0.
